// File: rtl/cla_pkg.sv
// Shared constants, stage-count helper and stage payload layout for the
// pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  // One register stage per lookahead group, never fewer than one.
  function automatic int cla_stages(input int width, input int group);
    return ((width / group) < 1) ? 1 : (width / group);
  endfunction

  // Stage payload at the default width; pipelined_cla_adder declares the
  // same layout sized to its own WIDTH.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] sum;
    logic                 carry;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every carry is formed
// directly from the generate/propagate terms and the slice carry-in.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] A,
  input  logic [GROUP-1:0] B,
  input  logic             CIN,
  output logic [GROUP-1:0] SUM,
  output logic             COUT
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP:0]   w_c;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, flattened per bit.
  always_comb begin
    logic v_carry;
    logic v_prop;
    w_c     = '0;
    w_c[0]  = CIN;
    v_carry = 1'b0;
    v_prop  = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      v_carry = w_g[i];
      v_prop  = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        v_carry = v_carry | (v_prop & w_g[j]);
        v_prop  = v_prop & w_p[j];
      end
      w_c[i+1] = v_carry | (v_prop & CIN);
    end
  end

  assign SUM  = w_p ^ w_c[GROUP-1:0];
  assign COUT = w_c[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, one lookahead group resolved per stage,
// valid/ready handshake with full backpressure. CLA_OVERFLOW_EN adds OVF.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef CLA_OVERFLOW_EN
  ,output logic            OVF
`endif
);

  localparam int STAGES = cla_stages(WIDTH, GROUP);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  function automatic stage_t merge_group(input stage_t s, input logic [GROUP-1:0] gsum,
                                         input logic gcarry, input int unsigned k);
    stage_t r;
    r = s;
    r.sum[k*GROUP +: GROUP] = gsum;
    r.carry = gcarry;
    return r;
  endfunction

  logic [STAGES-1:0] r_vld;
  stage_t            r_pay  [STAGES];
  stage_t            w_next [STAGES];
  logic [STAGES-1:0] w_vld_in;
  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_xfer;
`ifdef CLA_OVERFLOW_EN
  logic              r_ovf;
  logic              w_ovf_next;
`endif

  assign w_rdy[STAGES] = OUT_READY;
  assign w_xfer        = w_vld_in & w_rdy[STAGES-1:0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_in;
    logic [GROUP-1:0] w_gsum;
    logic             w_gcout;

    if (k == 0) begin : g_first
      assign w_in        = '{sum: '0, carry: CIN, a: A, b: B};
      assign w_vld_in[k] = IN_VALID;
    end else begin : g_rest
      assign w_in        = r_pay[k-1];
      assign w_vld_in[k] = r_vld[k-1];
    end

    assign w_rdy[k] = !r_vld[k] | w_rdy[k+1];

    cla_group #(.GROUP(GROUP)) u_group (
      .A    (w_in.a[k*GROUP +: GROUP]),
      .B    (w_in.b[k*GROUP +: GROUP]),
      .CIN  (w_in.carry),
      .SUM  (w_gsum),
      .COUT (w_gcout)
    );

    assign w_next[k] = merge_group(w_in, w_gsum, w_gcout, k);

`ifdef CLA_OVERFLOW_EN
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    if (k == STAGES - 1) begin : g_ovf
      assign w_ovf_next = w_gcout ^ (w_in.a[WIDTH-1] ^ w_in.b[WIDTH-1] ^ w_gsum[GROUP-1]);
    end
`endif
  end

  // Stage registers: valid follows ready; payload loads only on a transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld            <= '0;
      r_pay[STAGES-1]  <= '0;
`ifdef CLA_OVERFLOW_EN
      r_ovf            <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) r_vld[k] <= w_vld_in[k];
        if (w_xfer[k]) r_pay[k] <= w_next[k];
      end
`ifdef CLA_OVERFLOW_EN
      if (w_xfer[STAGES-1]) r_ovf <= w_ovf_next;
`endif
    end
  end

  assign IN_READY  = w_rdy[0];
  assign OUT_VALID = r_vld[STAGES-1];
  assign SUM       = r_pay[STAGES-1].sum;
  assign COUT      = r_pay[STAGES-1].carry;
`ifdef CLA_OVERFLOW_EN
  assign OVF       = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (16/4 main instance, 8/8 degenerate
// instance); OVF is checked when CLA_OVERFLOW_EN is defined.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY, CIN, OUT_VALID, OUT_READY, COUT;
  logic [15:0] A, B, SUM;
  logic        IN_VALID8, IN_READY8, CIN8, OUT_VALID8, OUT_READY8, COUT8;
  logic [7:0]  A8, B8, SUM8;
`ifdef CLA_OVERFLOW_EN
  logic        OVF, OVF8;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  vec_t sv[16];
  vec_t bp[6];
  vec_t rv[3];

  always #5 CLK = ~CLK;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef CLA_OVERFLOW_EN
    .OVF(OVF),
`endif
    .SUM(SUM), .COUT(COUT)
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID8), .IN_READY(IN_READY8),
    .A(A8), .B(B8), .CIN(CIN8), .OUT_VALID(OUT_VALID8), .OUT_READY(OUT_READY8),
`ifdef CLA_OVERFLOW_EN
    .OVF(OVF8),
`endif
    .SUM(SUM8), .COUT(COUT8)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.s  = v.s;
    e.co = v.co;
    e.ov = (v.a[15] == v.b[15]) && (v.s[15] != v.a[15]);
    q.push_back(e);
  endtask

  // Offer one operand until accepted (bounded); expected result queued on accept.
  task automatic send(input vec_t v, output int tries);
    logic r;
    r = 1'b0;
    tries = 0;
    A = v.a; B = v.b; CIN = v.c; IN_VALID = 1'b1;
    while (!r && tries < 20) begin
      @(negedge CLK);
      r = IN_READY;
      tries++;
      @(posedge CLK); #1;
    end
    if (r) push(v);
    else check("send_timeout", 32'd0, 32'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge CLK);
    #1;
    check("drain_empty", q.size(), 32'd0);
  endtask

  // Monitor: every output transfer pops and compares one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", SUM, e.s);
          check("cout", COUT, e.co);
`ifdef CLA_OVERFLOW_EN
          check("ovf", OVF, e.ov);
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   tries;
    int   acc;
    int   idx;
    logic r;
    vec_t v;

    sv = '{
      '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0},
      '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0},
      '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0},
      '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0},
      '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1},
      '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1},
      '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0},
      '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0},
      '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
      '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0},
      '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0},
      '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0},
      '{16'hC000, 16'h4000, 1'b0, 16'h0000, 1'b1},
      '{16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0},
      '{16'hDEAD, 16'hBEEF, 1'b0, 16'h9D9C, 1'b1}
    };
    bp = '{
      '{16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0},
      '{16'h0101, 16'h0101, 1'b1, 16'h0203, 1'b0},
      '{16'h8001, 16'h8001, 1'b0, 16'h0002, 1'b1},
      '{16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1},
      '{16'h3333, 16'h4444, 1'b0, 16'h7777, 1'b0},
      '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0}
    };
    rv = '{
      '{16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0},
      '{16'h2222, 16'h2222, 1'b0, 16'h4444, 1'b0},
      '{16'h3333, 16'h3333, 1'b0, 16'h6666, 1'b0}
    };

    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0; OUT_READY = 1'b1;
    IN_VALID8 = 1'b0; A8 = '0; B8 = '0; CIN8 = 1'b0; OUT_READY8 = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 32'd0);
    check("rst_sum", SUM, 32'd0);
    check("rst_cout", COUT, 32'd0);
    check("rst_in_ready", IN_READY, 32'd1);
`ifdef CLA_OVERFLOW_EN
    check("rst_ovf", OVF, 32'd0);
`endif
    @(posedge CLK); #1;

    // Carry ripple across all groups; result visible after the 4th edge.
    v = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    send(v, tries);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("latency_valid", OUT_VALID, (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge CLK); #1;
    drain();

    // Streaming: 16 back-to-back, each accepted on first offer.
    for (int i = 0; i < 16; i++) begin
      send(sv[i], tries);
      check("stream_ready", tries, 32'd1);
    end
    drain();

    // Backpressure: 6 cycles of offers with the consumer stalled.
    OUT_READY = 1'b0;
    acc = 0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      A = bp[idx].a; B = bp[idx].b; CIN = bp[idx].c; IN_VALID = 1'b1;
      @(negedge CLK);
      r = IN_READY;
      @(posedge CLK); #1;
      if (r) begin
        push(bp[idx]);
        idx++;
        acc++;
      end
    end
    check("bp_accepted", acc, 32'd4);
    @(negedge CLK);
    check("bp_in_ready", IN_READY, 32'd0);
    check("bp_out_valid", OUT_VALID, 32'd1);
    check("bp_sum_hold", SUM, 32'h0300);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("bp_sum_hold2", SUM, 32'h0300);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(bp[4], tries);
    check("full_drain_ready", tries, 32'd1);
    send(bp[5], tries);
    drain();

    // Reset with three operands in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) send(rv[i], tries);
    RST = 1'b1;
    q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("flush_out_valid", OUT_VALID, 32'd0);
    check("flush_sum", SUM, 32'd0);
    check("flush_cout", COUT, 32'd0);
    check("flush_in_ready", IN_READY, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("flush_no_stale", OUT_VALID, 32'd0);
    end
    @(posedge CLK); #1;

`ifdef CLA_OVERFLOW_EN
    v = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    send(v, tries);
    v = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    send(v, tries);
    drain();
`endif

    // Degenerate single-stage instance: 0x80 + 0x80 + 1.
    A8 = 8'h80; B8 = 8'h80; CIN8 = 1'b1; IN_VALID8 = 1'b1;
    @(negedge CLK);
    check("d8_in_ready", IN_READY8, 32'd1);
    @(posedge CLK); #1;
    IN_VALID8 = 1'b0;
    @(negedge CLK);
    check("d8_out_valid", OUT_VALID8, 32'd1);
    check("d8_sum", SUM8, 32'h01);
    check("d8_cout", COUT8, 32'd1);
`ifdef CLA_OVERFLOW_EN
    check("d8_ovf", OVF8, 32'd1);
`endif
    @(posedge CLK); #1;
    @(negedge CLK);
    check("d8_empty", OUT_VALID8, 32'd0);
    @(posedge CLK); #1;
    OUT_READY8 = 1'b0;
    A8 = 8'h01; B8 = 8'h01; CIN8 = 1'b0; IN_VALID8 = 1'b1;
    @(posedge CLK); #1;
    A8 = 8'h10;
    @(negedge CLK);
    check("d8_full_ready", IN_READY8, 32'd0);
    check("d8_hold_sum", SUM8, 32'h02);
    @(posedge CLK); #1;
    IN_VALID8 = 1'b0;
    OUT_READY8 = 1'b1;
    @(posedge CLK); #1;

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
